uart_fifo_bridge: RTL

//  Buffered byte-stream front end for uart_transmitter and uart_receiver.
//  - TX side: holds CPU/bus bytes in a FIFO and feeds them one at a time to the transmitter.
//  - RX side: captures each received byte into a FIFO and acknowledges the receiver.
//  - Exposes valid/ready streams and sticky overrun status to the bus-facing UART controller.

---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_fifo_bridge_if.sv | 34 +++
 rtl/uart_sync_fifo.sv | 47 ++++
 rtl/uart_fifo_bridge.sv | 111 +++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART FIFO bridge: byte type and the TX sequencing states.
package uart_pkg;
  typedef logic [7:0] uart_byte_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_SEND} tx_fsm_t;
endpackage

// File: rtl/uart_fifo_bridge_if.sv
// Bus-facing streams of the UART FIFO bridge plus its status/occupancy signals.
interface uart_fifo_bridge_if #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
);
  import uart_pkg::*;

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  // Handshake: a beat transfers on a rising clk edge where valid && ready are both 1;
  // valid never waits on ready, and data is stable whenever valid is high.
  uart_byte_t       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  uart_byte_t       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [TX_CW-1:0] tx_count;
  logic [RX_CW-1:0] rx_count;
  logic             rx_overrun;
  logic             overrun_clear;
  logic             tx_idle;

  modport master (
    output tx_data, tx_valid, rx_ready, overrun_clear,
    input  tx_ready, rx_data, rx_valid, tx_count, rx_count, rx_overrun, tx_idle
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready, overrun_clear,
    output tx_ready, rx_data, rx_valid, tx_count, rx_count, rx_overrun, tx_idle
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with extra-MSB binary pointers.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign count = wrPtr - rdPtr;
  assign head  = mem[rdPtr[AW-1:0]];

  // A push into a full FIFO is taken only when the head leaves in the same cycle.
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !rst) mem[wrPtr[AW-1:0]] <= pushData;
  end
endmodule

// File: rtl/uart_fifo_bridge.sv
// Buffers bytes between a bus-side stream and an external UART transmitter/receiver pair.
module uart_fifo_bridge
  import uart_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  uart_fifo_bridge_if.slave   bus,
  output logic                uart_tx_start,
  output uart_byte_t          uart_tx_data,
  input  logic                uart_tx_busy,
  input  uart_byte_t          uart_rx_data,
  input  logic                uart_rx_ready,
  output logic                uart_rx_clear,
  output tx_fsm_t             tx_state
);
  uart_byte_t txHead;
  logic       txFull, txEmpty, txPush, txPop;
  uart_byte_t rxHead;
  logic       rxFull, rxEmpty, rxEdge, rxPopOk, rxDrop;
  logic       rxReadyQ;

  tx_fsm_t    stateNext;
  logic       startNext;
  uart_byte_t dataNext;

  assign txPush       = bus.tx_valid & ~txFull;
  assign bus.tx_ready = ~txFull;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (txPush),
    .pushData (bus.tx_data),
    .pop      (txPop),
    .head     (txHead),
    .full     (txFull),
    .empty    (txEmpty),
    .count    (bus.tx_count)
  );

  // Start and data are registered; data holds until the next launch.
  always_comb begin
    stateNext = tx_state;
    startNext = 1'b0;
    dataNext  = uart_tx_data;
    txPop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!txEmpty && !uart_tx_busy) begin
          startNext = 1'b1;
          dataNext  = txHead;
          txPop     = 1'b1;
          stateNext = TX_START;
        end
      end
      TX_START: if (uart_tx_busy)  stateNext = TX_SEND;
      TX_SEND:  if (!uart_tx_busy) stateNext = TX_IDLE;
      default:  stateNext = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state      <= TX_IDLE;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= '0;
    end else begin
      tx_state      <= stateNext;
      uart_tx_start <= startNext;
      uart_tx_data  <= dataNext;
    end
  end

  assign bus.tx_idle = txEmpty & (tx_state == TX_IDLE) & ~uart_tx_busy;

  // Receiver holds ready until cleared, so only its rising edge captures a byte.
  assign rxEdge  = uart_rx_ready & ~rxReadyQ;
  assign rxPopOk = bus.rx_ready & ~rxEmpty;
  assign rxDrop  = rxEdge & rxFull & ~rxPopOk;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rxEdge),
    .pushData (uart_rx_data),
    .pop      (bus.rx_ready),
    .head     (rxHead),
    .full     (rxFull),
    .empty    (rxEmpty),
    .count    (bus.rx_count)
  );

  assign bus.rx_data  = rxHead;
  assign bus.rx_valid = ~rxEmpty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxReadyQ       <= 1'b0;
      uart_rx_clear  <= 1'b0;
      bus.rx_overrun <= 1'b0;
    end else begin
      rxReadyQ      <= uart_rx_ready;
      uart_rx_clear <= rxEdge;
      if (rxDrop)                 bus.rx_overrun <= 1'b1;
      else if (bus.overrun_clear) bus.rx_overrun <= 1'b0;
    end
  end
endmodule
